// File: rtl/pr_pkg.sv
// Shared types and helpers for the pr_load_sched sequencer.
package pr_pkg;

    // Ceiling log2, never less than 1 so it can size a counter directly.
    function automatic int C_LOG_2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_PFLAG,
        S_LD_P,
        S_LD_SFLAG,
        S_LD_S,
        S_START,
        S_ROW_ARM,
        S_ROW_RUN,
        S_FIN
    } state_t;

    // External buffer layout: pflag, p, sflag, s packed back to back.
    localparam int PFLAG_BASE = 0;

    function automatic int P_BASE(input int nb);
        return PFLAG_BASE + nb;
    endfunction

    function automatic int SFLAG_BASE(input int nb);
        return P_BASE(nb) + nb;
    endfunction

    function automatic int S_BASE(input int nb, input int ks);
        return SFLAG_BASE(nb) + ks;
    endfunction

endpackage

// File: rtl/pr_load_sched_if.sv
// External read port bundle: one outstanding request, data returned with rvalid.
interface pr_load_sched_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 9,
    parameter int ADDR_WIDTH  = 12
);
    logic                              ext_req;
    logic [ADDR_WIDTH-1:0]             ext_addr;
    logic                              ext_rvalid;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] ext_rdata;

    modport master (output ext_req, ext_addr, input ext_rvalid, ext_rdata);
    modport slave  (input ext_req, ext_addr, output ext_rvalid, ext_rdata);
endinterface

// File: rtl/pr_ext_rd_port.sv
// Read-port handshake: holds ext_req until rvalid, captures the beat and
// steps the address. A new request is only raised on issue_i.
module pr_ext_rd_port
    import pr_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 9,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              issue_i,
    input  logic                              addr_clr_i,
    pr_load_sched_if.master                   ext,
    output logic                              beat_o,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_o
);
    localparam int DW = DATA_WIDTH * KERNEL_SIZE;

    logic                  req_q,  req_d;
    logic                  beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         data_q, data_d;

    // Accept only while a request is outstanding; stray rvalid is dropped.
    always_comb begin
        req_d  = req_q;
        beat_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (req_q && ext.ext_rvalid) begin
            req_d  = 1'b0;
            beat_d = 1'b1;
            data_d = ext.ext_rdata;
            addr_d = addr_q + ADDR_WIDTH'(1);
        end else if (issue_i) begin
            req_d = 1'b1;
        end
        if (addr_clr_i) addr_d = ADDR_WIDTH'(PFLAG_BASE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q  <= 1'b0;
            beat_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            req_q  <= req_d;
            beat_q <= beat_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign ext.ext_req  = req_q;
    assign ext.ext_addr = addr_q;
    assign beat_o       = beat_q;
    assign data_o       = data_q;
endmodule

// File: rtl/pr_load_sched.sv
// Load sequencer in front of mem_controller: streams pflag/p/sflag/s from the
// external read port, pulses start, then paces row finish/cal pulses.
module pr_load_sched
    import pr_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int IF_WIDTH        = 16,
    parameter int KERNEL_WIDTH    = 3,
    parameter int KERNEL_SIZE     = KERNEL_WIDTH * KERNEL_WIDTH,
    parameter int NUM_BLOCK       = (IF_WIDTH / KERNEL_WIDTH + 1) * (IF_WIDTH / KERNEL_WIDTH + 1),
    parameter int ADDR_WIDTH      = 12,
    parameter int ACT_INDEX_WIDTH = C_LOG_2(IF_WIDTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_go,
    input  logic                              cfg_mode,
    output logic                              busy,
    output logic                              done,
    pr_load_sched_if.master                   ext,
    output logic                              wr_req_pflag,
    output logic [KERNEL_SIZE-1:0]            wr_data_pflag,
    output logic                              wr_req_p,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] wr_data_p,
    output logic                              wr_req_sflag,
    output logic [IF_WIDTH-1:0]               wr_data_sflag,
    output logic                              wr_req_s,
    output logic [DATA_WIDTH-1:0]             wr_data_s,
    output logic                              mode,
    output logic                              start,
    input  logic [ACT_INDEX_WIDTH-1:0]        row_val_num,
    input  logic                              zero_flag,
    input  logic                              pe_done,
    output logic                              row_finish_done_0,
    output logic                              row_cal_done
);
    localparam int AW = ACT_INDEX_WIDTH;
    localparam int BW = C_LOG_2(NUM_BLOCK) + 1;

    // Last beat index of each phase, from the buffer layout.
    localparam logic [BW-1:0] LAST_PFLAG = BW'(P_BASE(NUM_BLOCK) - PFLAG_BASE - 1);
    localparam logic [BW-1:0] LAST_P     = BW'(SFLAG_BASE(NUM_BLOCK) - P_BASE(NUM_BLOCK) - 1);
    localparam logic [BW-1:0] LAST_SFLAG = BW'(S_BASE(NUM_BLOCK, KERNEL_SIZE) - SFLAG_BASE(NUM_BLOCK) - 1);
    localparam logic [BW-1:0] LAST_S     = BW'(KERNEL_SIZE - 1);
    localparam logic [AW-1:0] LAST_ROW   = AW'(IF_WIDTH - 1);

    state_t                         state_q;
    logic [BW-1:0]                  beat_cnt_q;
    logic [AW-1:0]                  row_cnt_q;
    logic [AW-1:0]                  fin_cnt_q;
    logic [AW-1:0]                  rv_q;
    logic                           mode_q;
    logic                           start_q;
    logic                           fin_q;
    logic                           cal_q;
    logic                           done_q;

    logic                           beat;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] rd_data;
    logic                           launch;
    logic                           issue;
    logic [BW-1:0]                  phase_lim;
    logic                           phase_last;
    logic [AW-1:0]                  fin_nxt;

    pr_ext_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNEL_SIZE(KERNEL_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd (
        .clk       (clk),
        .reset     (reset),
        .issue_i   (issue),
        .addr_clr_i(launch),
        .ext       (ext),
        .beat_o    (beat),
        .data_o    (rd_data)
    );

    // Phase bookkeeping and next-request decision; no request after the last s beat.
    always_comb begin
        launch  = (state_q == S_IDLE) && cfg_go;
        fin_nxt = fin_cnt_q + AW'(1);
        case (state_q)
            S_LD_PFLAG: phase_lim = LAST_PFLAG;
            S_LD_P:     phase_lim = LAST_P;
            S_LD_SFLAG: phase_lim = LAST_SFLAG;
            S_LD_S:     phase_lim = LAST_S;
            default:    phase_lim = '0;
        endcase
        phase_last = (beat_cnt_q == phase_lim);
        issue      = launch || (beat && !((state_q == S_LD_S) && phase_last));
    end

    // Main sequencer: load phases, start, row pacing, completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            fin_cnt_q  <= '0;
            rv_q       <= '0;
            mode_q     <= 1'b0;
            start_q    <= 1'b0;
            fin_q      <= 1'b0;
            cal_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            fin_q   <= 1'b0;
            cal_q   <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_go) begin
                        state_q    <= S_LD_PFLAG;
                        mode_q     <= cfg_mode;
                        beat_cnt_q <= '0;
                        row_cnt_q  <= '0;
                    end
                end
                S_LD_PFLAG, S_LD_P, S_LD_SFLAG, S_LD_S: begin
                    if (beat) begin
                        if (phase_last) begin
                            beat_cnt_q <= '0;
                            case (state_q)
                                S_LD_PFLAG: state_q <= S_LD_P;
                                S_LD_P:     state_q <= S_LD_SFLAG;
                                S_LD_SFLAG: state_q <= S_LD_S;
                                default: begin
                                    state_q <= S_START;
                                    start_q <= 1'b1;
                                end
                            endcase
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BW'(1);
                        end
                    end
                end
                S_START: state_q <= S_ROW_ARM;
                S_ROW_ARM: begin
                    fin_cnt_q <= '0;
                    rv_q      <= row_val_num;
                    // Single-shot mode and empty rows finish without PE work.
                    if (!mode_q || zero_flag) begin
                        fin_q <= 1'b1;
                        cal_q <= 1'b1;
                        if (!mode_q || row_cnt_q == LAST_ROW) begin
                            state_q <= S_FIN;
                        end else begin
                            row_cnt_q <= row_cnt_q + AW'(1);
                            state_q   <= S_ROW_ARM;
                        end
                    end else begin
                        state_q <= S_ROW_RUN;
                    end
                end
                S_ROW_RUN: begin
                    if (pe_done) begin
                        fin_q     <= 1'b1;
                        fin_cnt_q <= fin_nxt;
                        if (fin_nxt == rv_q) begin
                            cal_q <= 1'b1;
                            if (row_cnt_q == LAST_ROW) begin
                                state_q <= S_FIN;
                            end else begin
                                row_cnt_q <= row_cnt_q + AW'(1);
                                state_q   <= S_ROW_ARM;
                            end
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign mode              = mode_q;
    assign start             = start_q;
    assign row_finish_done_0 = fin_q;
    assign row_cal_done      = cal_q;

    assign wr_req_pflag  = beat && (state_q == S_LD_PFLAG);
    assign wr_req_p      = beat && (state_q == S_LD_P);
    assign wr_req_sflag  = beat && (state_q == S_LD_SFLAG);
    assign wr_req_s      = beat && (state_q == S_LD_S);
    assign wr_data_pflag = rd_data[KERNEL_SIZE-1:0];
    assign wr_data_p     = rd_data;
    assign wr_data_sflag = rd_data[IF_WIDTH-1:0];
    assign wr_data_s     = rd_data[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_pr_load_sched.sv
// Directed/randomized bench for pr_load_sched with a transaction-level model.
module tb_pr_load_sched;
    localparam int NB    = 36;
    localparam int KS    = 9;
    localparam int NWORD = 2 * NB + 2 * KS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_go = 1'b0;
    logic        cfg_mode = 1'b0;
    logic        busy, done, mode, start;
    logic        wr_req_pflag, wr_req_p, wr_req_sflag, wr_req_s;
    logic [8:0]  wr_data_pflag;
    logic [71:0] wr_data_p;
    logic [15:0] wr_data_sflag;
    logic [7:0]  wr_data_s;
    logic [3:0]  row_val_num = '0;
    logic        zero_flag = 1'b0;
    logic        pe_done = 1'b0;
    logic        row_finish_done_0, row_cal_done;

    logic [71:0] mem [NWORD];
    int          nt = 0;
    int          nb = 0;

    pr_load_sched_if #(.DATA_WIDTH(8), .KERNEL_SIZE(9), .ADDR_WIDTH(12)) ext_if ();

    pr_load_sched dut (
        .clk(clk), .reset(reset), .cfg_go(cfg_go), .cfg_mode(cfg_mode),
        .busy(busy), .done(done), .ext(ext_if.master),
        .wr_req_pflag(wr_req_pflag), .wr_data_pflag(wr_data_pflag),
        .wr_req_p(wr_req_p), .wr_data_p(wr_data_p),
        .wr_req_sflag(wr_req_sflag), .wr_data_sflag(wr_data_sflag),
        .wr_req_s(wr_req_s), .wr_data_s(wr_data_s),
        .mode(mode), .start(start), .row_val_num(row_val_num),
        .zero_flag(zero_flag), .pe_done(pe_done),
        .row_finish_done_0(row_finish_done_0), .row_cal_done(row_cal_done)
    );

    always #5 clk = ~clk;

    logic [3:0] out_ev;
    logic [3:0] wr_ev;
    assign out_ev = {start, row_finish_done_0, row_cal_done, done};
    assign wr_ev  = {wr_req_pflag, wr_req_p, wr_req_sflag, wr_req_s};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nt++;
        assert (obs === exp) else begin
            nb++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag, input logic [3:0] e);
        step();
        chk(tag, out_ev, e);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_req"}, ext_if.ext_req, 1'b0);
        chk({tag, "_wr"}, wr_ev, 4'b0000);
        chk({tag, "_ev"}, out_ev, 4'b0000);
    endtask

    task automatic launch(input logic m);
        chk("pre_go_busy", busy, 1'b0);
        cfg_mode = m;
        cfg_go   = 1'b1;
        step();
        cfg_go   = 1'b0;
        chk("go_req", ext_if.ext_req, 1'b1);
        chk("go_addr", ext_if.ext_addr, 12'd0);
        chk("go_busy", busy, 1'b1);
        chk("go_mode", mode, m);
    endtask

    // Serve all 90 reads with random latency; check strobe routing and data.
    task automatic load(input int dmin, input int dmax, input bit spur, input int abort_at, input int glitch_at);
        for (int i = 0; i < NWORD; i++) begin
            int          d;
            logic [71:0] w;
            logic [3:0]  exp_wr;
            d = $urandom_range(dmax, dmin);
            w = mem[i];
            exp_wr = (i < NB) ? 4'b1000 : (i < 2 * NB) ? 4'b0100 : (i < 2 * NB + KS) ? 4'b0010 : 4'b0001;
            chk("req_up", ext_if.ext_req, 1'b1);
            chk("addr", ext_if.ext_addr, 12'(i));
            for (int k = 0; k < d; k++) begin
                step();
                chk("req_hold", {ext_if.ext_req, ext_if.ext_addr}, {1'b1, 12'(i)});
                chk("no_wr_wait", wr_ev, 4'b0000);
            end
            ext_if.ext_rvalid = 1'b1;
            ext_if.ext_rdata  = w;
            step();
            ext_if.ext_rvalid = 1'b0;
            ext_if.ext_rdata  = {$urandom, $urandom, $urandom};
            chk("wr_strobe", wr_ev, exp_wr);
            chk("req_drop", ext_if.ext_req, 1'b0);
            if (exp_wr[3]) chk("d_pflag", wr_data_pflag, w[8:0]);
            if (exp_wr[2]) chk("d_p", wr_data_p, w);
            if (exp_wr[1]) chk("d_sflag", wr_data_sflag, w[15:0]);
            if (exp_wr[0]) chk("d_s", wr_data_s, w[7:0]);
            if (i == abort_at) begin
                reset = 1'b1;
                step();
                chk_quiet("abort1");
                step();
                reset = 1'b0;
                chk_quiet("abort2");
                chk("abort_mode", mode, 1'b0);
                return;
            end
            if (spur && i < NWORD - 1) ext_if.ext_rvalid = 1'b1;
            if (i == glitch_at) cfg_go = 1'b1;
            step();
            ext_if.ext_rvalid = 1'b0;
            cfg_go = 1'b0;
            chk((i == NWORD - 1) ? "start_pulse" : "no_ev_load", out_ev, (i == NWORD - 1) ? 4'b1000 : 4'b0000);
        end
    endtask

    // Rows: expected finish count per row is 1 for empty rows / single-shot,
    // otherwise row_val_num, with cal on the last one.
    task automatic run_rows(input logic m, input int rv_fix, input int gap_fix, input bit z_row0);
        int nrows;
        nrows = m ? 16 : 1;
        pe_done = 1'($urandom_range(1, 0));
        tick("start_to_arm", 4'b0000);
        for (int r = 0; r < nrows; r++) begin
            bit z;
            int rv;
            rv = (rv_fix != 0) ? rv_fix : $urandom_range(5, 1);
            z  = m && ((r == 0 && z_row0) || (rv_fix == 0 && $urandom_range(3, 0) == 0));
            row_val_num = 4'(rv);
            zero_flag   = m ? z : 1'b0;
            pe_done     = 1'($urandom_range(1, 0));
            if (!m || z) begin
                tick("row_imm", 4'b0110);
            end else begin
                tick("arm", 4'b0000);
                for (int k = 0; k < rv; k++) begin
                    int g;
                    g = (gap_fix >= 0) ? gap_fix : $urandom_range(2, 0);
                    for (int j = 0; j < g; j++) begin
                        pe_done = 1'b0;
                        tick("pe_gap", 4'b0000);
                    end
                    pe_done = 1'b1;
                    tick((k == rv - 1) ? "row_cal" : "row_fin", {2'b01, (k == rv - 1), 1'b0});
                end
            end
        end
        pe_done   = 1'b0;
        zero_flag = 1'b0;
        tick("done_pulse", 4'b0001);
        chk("done_busy", busy, 1'b0);
        tick("after_done", 4'b0000);
    endtask

    initial begin
        ext_if.ext_rvalid = 1'b0;
        ext_if.ext_rdata  = '0;
        for (int i = 0; i < NWORD; i++) mem[i] = {$urandom, $urandom, $urandom};

        step(); step(); step();
        chk_quiet("rst");
        chk("rst_mode", mode, 1'b0);
        chk("rst_addr", ext_if.ext_addr, 12'd0);
        chk("rst_data", {wr_data_p, wr_data_pflag, wr_data_sflag, wr_data_s}, '0);
        reset = 1'b0;
        step();
        chk_quiet("idle");

        // PE completion outside a run must not produce pulses.
        pe_done = 1'b1;
        tick("idle_pe", 4'b0000);
        pe_done = 1'b0;
        tick("idle_pe2", 4'b0000);

        // Abort mid-p load, then a clean single-shot run with 1-cycle latency.
        launch(1'b1);
        load(0, 2, 1'b0, NB + 10, -1);
        launch(1'b0);
        load(1, 1, 1'b0, -1, -1);
        run_rows(1'b0, 0, -1, 1'b0);

        // Per-row pacing, 3 weights per row, pe_done every 3 cycles.
        launch(1'b1);
        load(0, 2, 1'b0, -1, -1);
        run_rows(1'b1, 3, 2, 1'b0);

        // Slow reads with stray rvalid, go during LD_S, empty first row.
        launch(1'b1);
        load(5, 5, 1'b1, -1, 2 * NB + KS + 3);
        run_rows(1'b1, 0, -1, 1'b1);

        // Fully random run.
        launch(1'b1);
        load(0, 3, 1'($urandom_range(1, 0)), -1, -1);
        run_rows(1'b1, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", nt, nb);
        $finish;
    end
endmodule
